// File: rtl/seq_dect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_dect_pkg
// Brief    : Shared constants and helpers for the programmable pattern detector
// Revision : 1.0
// ============================================================================
package seq_dect_pkg;

    localparam logic [3:0] c_def_pattern = 4'b1011;

    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // The mask is 32 bits wide, so patterns are limited to 32 bits.
    function automatic logic [31:0] len_mask(input int len);
        if (len >= 32)
            return '1;
        return (32'd1 << len) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_match_cnt.sv
`default_nettype none
// ============================================================================
// Module   : seq_match_cnt
// Brief    : Saturating match counter; a clear takes priority over an increment
// Revision : 1.0
// ============================================================================
module seq_match_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (inc && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/seq_dect_prog.sv
`default_nettype none
// ============================================================================
// Module   : seq_dect_prog
// Brief    : Run-time programmable serial pattern detector with match counter
// Revision : 1.0
// ============================================================================
module seq_dect_prog
    import seq_dect_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(c_def_pattern),
    parameter int               CNT_W       = 8,
    localparam int              LEN_W       = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             seq_in,
    input  logic             overlap,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cnt_clr,
    output logic             dect_out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err
);

    localparam logic [LEN_W-1:0] c_pat_w_len = LEN_W'(PAT_W);

    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    // The oldest history bit is never needed again, so only PAT_W-1 bits are kept.
    logic [PAT_W-2:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic             r_dect;
    logic             r_cfg_err;

    logic             w_len_ok;
    logic             w_load;
    logic             w_shift;
    logic [PAT_W-1:0] w_hist_next;
    logic [LEN_W-1:0] w_fill_next;
    logic [31:0]      w_mask;
    logic             w_match;

    assign w_len_ok    = (cfg_len != '0) && (cfg_len <= c_pat_w_len);
    assign w_load      = cfg_load && w_len_ok;
    assign w_shift     = en && !w_load;
    assign w_hist_next = {r_hist, seq_in};
    assign w_fill_next = (r_fill == c_pat_w_len) ? r_fill : r_fill + 1'b1;
    assign w_mask      = len_mask(int'(r_len));
    assign w_match     = w_shift && (w_fill_next >= r_len) &&
                         ((32'(w_hist_next ^ r_pat) & w_mask) == 32'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pat     <= DEF_PATTERN;
            r_len     <= c_pat_w_len;
            r_hist    <= '0;
            r_fill    <= '0;
            r_dect    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_dect    <= w_match;
            r_cfg_err <= cfg_load && !w_len_ok;
            if (w_load) begin
                r_pat  <= cfg_pattern;
                r_len  <= cfg_len;
                r_hist <= '0;
                r_fill <= '0;
            end else if (w_shift) begin
                r_hist <= w_hist_next[PAT_W-2:0];
                r_fill <= (w_match && !overlap) ? '0 : w_fill_next;
            end
        end
    end

    seq_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_match),
        .clr     (cnt_clr),
        .cnt     (match_cnt)
    );

    assign dect_out = r_dect;
    assign cfg_err  = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_dect_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_dect_prog
// Brief    : Directed self-checking bench with a reference model and scoreboard
// Revision : 1.0
// ============================================================================
module tb_seq_dect_prog;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       seq_in = 1'b0;
    logic       overlap = 1'b0;
    logic       cfg_load = 1'b0;
    logic [3:0] cfg_pattern = 4'b0;
    logic [2:0] cfg_len = 3'd0;
    logic       cnt_clr = 1'b0;
    logic       dect_out, cfg_err, dect_out2, cfg_err2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic       dect;
        logic       err;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [3:0] m_pat;
    int         m_len;
    bit         m_bits[$];
    logic [7:0] m_cnt8;
    logic [1:0] m_cnt2;

    always #5 clk = ~clk;

    seq_dect_prog #(.PAT_W(4), .CNT_W(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .en(en), .seq_in(seq_in), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cnt_clr(cnt_clr), .dect_out(dect_out), .match_cnt(match_cnt), .cfg_err(cfg_err)
    );

    seq_dect_prog #(.PAT_W(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .en(en), .seq_in(seq_in), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cnt_clr(cnt_clr), .dect_out(dect_out2), .match_cnt(match_cnt2), .cfg_err(cfg_err2)
    );

    function automatic void model_reset();
        m_pat  = 4'b1011;
        m_len  = 4;
        m_bits.delete();
        m_cnt8 = '0;
        m_cnt2 = '0;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive, predict and queue, then compare after the edge.
    task automatic step(input logic e, input logic s, input logic ov, input logic ld,
                        input logic [3:0] p, input logic [2:0] l, input logic clr,
                        input string tag);
        exp_t ex;
        bit   legal, hit;
        int   n;
        @(negedge clk);
        en = e; seq_in = s; overlap = ov; cfg_load = ld;
        cfg_pattern = p; cfg_len = l; cnt_clr = clr;
        legal = (l >= 3'd1) && (l <= 3'd4);
        hit = 1'b0;
        if (ld && legal) begin
            m_pat = p;
            m_len = int'(l);
            m_bits.delete();
        end else if (e) begin
            m_bits.push_back(s);
            if (m_bits.size() > 4) void'(m_bits.pop_front());
            n = m_bits.size();
            if (n >= m_len) begin
                hit = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (m_bits[n - m_len + i] != m_pat[m_len - 1 - i]) hit = 1'b0;
            end
            if (hit && !ov) m_bits.delete();
        end
        if (clr) begin
            m_cnt8 = '0;
            m_cnt2 = '0;
        end else if (hit) begin
            if (m_cnt8 != 8'hFF) m_cnt8 = m_cnt8 + 8'd1;
            if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
        end
        ex.dect = hit;
        ex.err  = ld && !legal;
        ex.cnt8 = m_cnt8;
        ex.cnt2 = m_cnt2;
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        ex = exp_q.pop_front();
        check({tag, " dect"},  8'(dect_out),   8'(ex.dect));
        check({tag, " dect2"}, 8'(dect_out2),  8'(ex.dect));
        check({tag, " err"},   8'(cfg_err),    8'(ex.err));
        check({tag, " cnt8"},  match_cnt,      ex.cnt8);
        check({tag, " cnt2"},  8'(match_cnt2), 8'(ex.cnt2));
    endtask

    task automatic feed(input logic s, input logic ov, input string tag);
        step(1'b1, s, ov, 1'b0, 4'b0, 3'd4, 1'b0, tag);
    endtask

    task automatic load(input logic [3:0] p, input logic [2:0] l, input logic clr, input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b1, p, l, clr, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] s1;
        s1 = 7'b1011011;
        model_reset();
        #12;
        check("reset dect",  8'(dect_out),   8'd0);
        check("reset cnt8",  match_cnt,      8'd0);
        check("reset err",   8'(cfg_err),    8'd0);
        check("reset cnt2",  8'(match_cnt2), 8'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Default 1011, overlapping
        for (int i = 6; i >= 0; i--) feed(s1[i], 1'b1, "ovl1011");

        // Same stream, non-overlapping, counters cleared on reload
        load(4'b1011, 3'd4, 1'b1, "reload");
        for (int i = 6; i >= 0; i--) feed(s1[i], 1'b0, "novl1011");

        // 111 with a don't-care upper pattern bit
        load(4'b1111, 3'd3, 1'b0, "load111");
        for (int i = 0; i < 5; i++) feed(1'b1, 1'b1, "ovl111");
        load(4'b0111, 3'd3, 1'b0, "load111b");
        for (int i = 0; i < 5; i++) feed(1'b1, 1'b0, "novl111");

        // en gaps inside 1011
        load(4'b1011, 3'd4, 1'b1, "load1011");
        feed(1'b1, 1'b1, "engap");
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0, 3'd4, 1'b0, "engap idle");
        feed(1'b0, 1'b1, "engap");
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0, 3'd4, 1'b0, "engap idle");
        feed(1'b1, 1'b1, "engap");
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0, 3'd4, 1'b0, "engap idle");
        feed(1'b1, 1'b1, "engap");
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0, 3'd4, 1'b0, "engap idle");

        // Illegal lengths: error pulse, bit still shifted, pattern kept
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 3'd0, 1'b0, "len0");
        feed(1'b0, 1'b1, "len0 tail");
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 3'd5, 1'b0, "len5");
        feed(1'b1, 1'b1, "len5 tail");
        // Legal load with en=1 drops the bit
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1011, 3'd4, 1'b0, "loaddrop");
        feed(1'b0, 1'b1, "drop tail");
        feed(1'b1, 1'b1, "drop tail");
        feed(1'b1, 1'b1, "drop tail");

        // cnt_clr coincident with a match
        load(4'b1011, 3'd4, 1'b0, "loadclr");
        feed(1'b1, 1'b1, "clrhit");
        feed(1'b0, 1'b1, "clrhit");
        feed(1'b1, 1'b1, "clrhit");
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0, 3'd4, 1'b1, "clrhit last");

        // Saturation of the 2-bit counter with length-2 pattern 11
        load(4'b0011, 3'd2, 1'b0, "load11");
        for (int i = 0; i < 6; i++) feed(1'b1, 1'b1, "sat");

        // Asynchronous reset mid-pattern
        load(4'b1011, 3'd4, 1'b0, "loadrst");
        feed(1'b1, 1'b1, "prerst");
        feed(1'b0, 1'b1, "prerst");
        feed(1'b1, 1'b1, "prerst");
        @(negedge clk);
        en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async dect", 8'(dect_out),   8'd0);
        check("async cnt8", match_cnt,      8'd0);
        check("async cnt2", 8'(match_cnt2), 8'd0);
        check("async err",  8'(cfg_err),    8'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        feed(1'b1, 1'b1, "postrst");
        feed(1'b1, 1'b1, "postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
